// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped write-through D-cache
// controller: line/transaction records and the LSQ/memory bus commands.
package dcache_ctrl_pkg;

  localparam int NUM_LINES = 32;
  localparam int IDX_W     = 5;
  localparam int NUM_TXN   = 4;
  localparam int LTAG_W    = 32 - 3 - IDX_W;
  localparam int SEL_W     = (NUM_TXN > 1) ? $clog2(NUM_TXN) : 1;

  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [LTAG_W-1:0] tag;
    logic [63:0]       data;
  } dcache_line_t;

  typedef struct packed {
    logic              valid;
    logic [3:0]        proc_tag;
    logic [3:0]        mem_tag;
    logic [IDX_W-1:0]  idx;
    logic [LTAG_W-1:0] ltag;
    logic              no_fill;
  } dcache_txn_t;

  // LSQ tags run 1..15; 0 is reserved for "refused / no data".
  function automatic logic [3:0] next_tag(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

endpackage

// File: rtl/dcache_txn_table.sv
// Outstanding load-miss table: free-slot search, proc-tag in-use check,
// fill lookup by memory tag, and store-driven no_fill marking.
module dcache_txn_table
  import dcache_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        cand_tag,
  input  logic [3:0]        mem_tag,
  input  logic              alloc_en,
  input  logic [3:0]        alloc_mem_tag,
  input  logic              store_en,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic [LTAG_W-1:0] req_ltag,
  output logic              cand_in_use,
  output logic              free_avail,
  output logic              fill_now,
  output logic [3:0]        fill_proc_tag,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [LTAG_W-1:0] fill_ltag,
  output logic              fill_install
);

  dcache_txn_t [NUM_TXN-1:0] slot_q, slot_d;
  logic [NUM_TXN-1:0]        same_blk;
  logic [SEL_W-1:0]          free_sel, fill_sel;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    cand_in_use = 1'b0;
    free_avail  = 1'b0;
    free_sel    = '0;
    fill_now    = 1'b0;
    fill_sel    = '0;
    same_blk    = '0;
    for (int i = NUM_TXN - 1; i >= 0; i--) begin
      same_blk[i] = slot_q[i].valid && slot_q[i].idx == req_idx && slot_q[i].ltag == req_ltag;
      if (slot_q[i].valid && slot_q[i].proc_tag == cand_tag) cand_in_use = 1'b1;
      if (!slot_q[i].valid) begin
        free_avail = 1'b1;
        free_sel   = SEL_W'(i);
      end
      if (slot_q[i].valid && mem_tag != 4'd0 && slot_q[i].mem_tag == mem_tag) begin
        fill_now = 1'b1;
        fill_sel = SEL_W'(i);
      end
    end
  end

  assign fill_proc_tag = slot_q[fill_sel].proc_tag;
  assign fill_idx      = slot_q[fill_sel].idx;
  assign fill_ltag     = slot_q[fill_sel].ltag;
  // A store accepted this same cycle counts as already applied.
  assign fill_install  = fill_now && !slot_q[fill_sel].no_fill && !(store_en && same_blk[fill_sel]);

  always_comb begin
    slot_d = slot_q;
    for (int i = 0; i < NUM_TXN; i++) begin
      if (store_en && same_blk[i]) slot_d[i].no_fill = 1'b1;
      if (fill_now && fill_sel == SEL_W'(i)) slot_d[i].valid = 1'b0;
      if (alloc_en && free_sel == SEL_W'(i))
        slot_d[i] = '{valid: 1'b1, proc_tag: cand_tag, mem_tag: alloc_mem_tag,
                      idx: req_idx, ltag: req_ltag, no_fill: 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) slot_q <= '0;
    else          slot_q <= slot_d;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Non-blocking direct-mapped, write-through, no-write-allocate D-cache
// controller between the LSQ and the memory bus.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  proc_command,
  input  logic [31:0] proc_addr,
  input  logic [63:0] proc_data,
  output logic [3:0]  proc_response,
  output logic [63:0] proc_data_out,
  output logic [3:0]  proc_tag,
  output logic [1:0]  mem_command,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_data,
  input  logic [3:0]  mem_response,
  input  logic [63:0] mem_data_in,
  input  logic [3:0]  mem_tag
);

  dcache_line_t [NUM_LINES-1:0] lines_q, lines_d;
  logic [3:0]        ctr_q, ctr_d, ptag_q, ptag_d;
  logic [63:0]       pdata_q, pdata_d;
  logic [IDX_W-1:0]  idx, fill_idx;
  logic [LTAG_W-1:0] ltag, fill_ltag;
  logic [3:0]        fill_proc_tag;
  logic              hit, is_load, is_store, alloc_en, store_en;
  logic              cand_in_use, free_avail, fill_now, fill_install;
  logic              unused_addr_lsb;

  assign idx             = proc_addr[3+IDX_W-1:3];
  assign ltag            = proc_addr[31:3+IDX_W];
  assign unused_addr_lsb = ^proc_addr[2:0];
  assign hit             = lines_q[idx].valid && lines_q[idx].tag == ltag;
  assign is_load         = proc_command == BUS_LOAD;
  assign is_store        = proc_command == BUS_STORE;
  assign mem_addr        = {proc_addr[31:3], 3'b000};
  assign mem_data        = proc_data;
  assign proc_tag        = ptag_q;
  assign proc_data_out   = pdata_q;

  dcache_txn_table u_txn (
    .clk           (clk),
    .reset_n       (reset_n),
    .cand_tag      (ctr_q),
    .mem_tag       (mem_tag),
    .alloc_en      (alloc_en),
    .alloc_mem_tag (mem_response),
    .store_en      (store_en),
    .req_idx       (idx),
    .req_ltag      (ltag),
    .cand_in_use   (cand_in_use),
    .free_avail    (free_avail),
    .fill_now      (fill_now),
    .fill_proc_tag (fill_proc_tag),
    .fill_idx      (fill_idx),
    .fill_ltag     (fill_ltag),
    .fill_install  (fill_install)
  );

  always_comb begin
    proc_response = 4'd0;
    mem_command   = BUS_NONE;
    alloc_en      = 1'b0;
    store_en      = 1'b0;
    ctr_d         = ctr_q;
    lines_d       = lines_q;
    ptag_d        = 4'd0;
    pdata_d       = pdata_q;
    if ((is_load || is_store) && cand_in_use) begin
      // Tag still owned by an outstanding miss: burn it and retry next cycle.
      ctr_d = next_tag(ctr_q);
    end else if (is_load) begin
      if (hit) begin
        if (!fill_now) begin
          proc_response = ctr_q;
          ctr_d         = next_tag(ctr_q);
          ptag_d        = ctr_q;
          pdata_d       = lines_q[idx].data;
        end
      end else if (free_avail) begin
        mem_command = BUS_LOAD;
        if (mem_response != 4'd0) begin
          proc_response = ctr_q;
          ctr_d         = next_tag(ctr_q);
          alloc_en      = 1'b1;
        end
      end
    end else if (is_store) begin
      mem_command = BUS_STORE;
      if (mem_response != 4'd0) begin
        proc_response = ctr_q;
        ctr_d         = next_tag(ctr_q);
        store_en      = 1'b1;
        if (hit) lines_d[idx].data = proc_data;
      end
    end
    if (fill_now) begin
      ptag_d  = fill_proc_tag;
      pdata_d = mem_data_in;
      if (fill_install) lines_d[fill_idx] = '{valid: 1'b1, tag: fill_ltag, data: mem_data_in};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lines_q <= '0;
      ctr_q   <= 4'd1;
      ptag_q  <= 4'd0;
      pdata_q <= 64'd0;
    end else begin
      lines_q <= lines_d;
      ctr_q   <= ctr_d;
      ptag_q  <= ptag_d;
      pdata_q <= pdata_d;
    end
  end

endmodule
